// File: rtl/hazard_tag_pipe_pkg.sv
// Shared definitions for the hazard tag pipeline and the stall detector:
// result-class codes, the (class, A3) tag, opcode/funct constants,
// forwarding-select encodings and the forwarding priority helpers.
package hazard_tag_pipe_pkg;

  typedef enum logic [1:0] {
    RES_NW  = 2'b00,
    RES_ALU = 2'b01,
    RES_DM  = 2'b10,
    RES_PC  = 2'b11
  } res_class_e;

  typedef struct packed {
    res_class_e res;
    logic [4:0] a3;
  } tag_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Forwarding selects; 00 means "no forward" for every consumer stage.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_E    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_W    = 2'b11;

  function automatic logic is_muldiv(input logic [31:0] instr);
    return (instr[31:26] == OP_RTYPE) &&
           ((instr[5:0] == FN_MULT) || (instr[5:0] == FN_MULTU) ||
            (instr[5:0] == FN_DIV)  || (instr[5:0] == FN_DIVU));
  endfunction

  // D-stage operand select. The nearest producer decides: if its value is
  // not yet available (ALU/DM in E, DM in M) nothing is forwarded and the
  // stall detector holds D instead of reading a stale older copy.
  function automatic logic [1:0] fwd_d_sel(input logic [4:0] src, input tag_t e,
                                           input tag_t m, input tag_t w);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (src == 5'd0)                            sel = FWD_NONE;
    else if (e.res != RES_NW && e.a3 == src)    sel = (e.res == RES_PC) ? FWD_E : FWD_NONE;
    else if (m.res != RES_NW && m.a3 == src)    sel = (m.res == RES_DM) ? FWD_NONE : FWD_M;
    else if (w.res != RES_NW && w.a3 == src)    sel = FWD_W;
    return sel;
  endfunction

  // E-stage operand select: M if its result is computed, otherwise W.
  function automatic logic [1:0] fwd_e_sel(input logic [4:0] src, input tag_t m,
                                           input tag_t w);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (src == 5'd0)                            sel = FWD_NONE;
    else if (m.res != RES_NW && m.a3 == src)    sel = (m.res == RES_DM) ? FWD_NONE : FWD_M;
    else if (w.res != RES_NW && w.a3 == src)    sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_tag_pipe_decode.sv
// Purely combinational decode of a D-stage instruction into its
// (result class, destination register) tag.
module hazard_tag_decode
  import hazard_tag_pipe_pkg::*;
#(
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic [31:0] instr_i,
  output tag_t        tag_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  res_class_e res_raw;
  logic [4:0] a3_raw;
  logic       unused_fields;

  assign op    = instr_i[31:26];
  assign rt    = instr_i[20:16];
  assign rd    = instr_i[15:11];
  assign funct = instr_i[5:0];
  assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

  // Class/destination lookup; a zero destination is demoted to NW below.
  always_comb begin
    res_raw = RES_NW;
    a3_raw  = 5'd0;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_JR || is_muldiv(instr_i)) begin
          res_raw = RES_NW;
          a3_raw  = 5'd0;
        end else if (funct == FN_JALR) begin
          res_raw = RES_PC;
          a3_raw  = rd;
        end else begin
          res_raw = RES_ALU;
          a3_raw  = rd;
        end
      end
      OP_ORI, OP_ANDI, OP_ADDIU, OP_ADDI, OP_LUI, OP_SLTI: begin
        res_raw = RES_ALU;
        a3_raw  = rt;
      end
      OP_LW, OP_LH, OP_LB, OP_LBU, OP_LHU: begin
        res_raw = RES_DM;
        a3_raw  = rt;
      end
      OP_JAL: begin
        res_raw = RES_PC;
        a3_raw  = RA_REG;
      end
      OP_SW, OP_BEQ, OP_BNE, OP_J: begin
        res_raw = RES_NW;
        a3_raw  = 5'd0;
      end
      default: begin
        res_raw = RES_NW;
        a3_raw  = 5'd0;
      end
    endcase
  end

  assign tag_o.res = (a3_raw == 5'd0) ? RES_NW : res_raw;
  assign tag_o.a3  = a3_raw;

endmodule

// File: rtl/hazard_tag_pipe.sv
// Producer side of the stall-detection interface: carries the decoded
// (class, A3) tag through E/M/W, bubbles E on stall/flush, and derives the
// forwarding-mux selects. Optional MULDIV_BUSY_EN adds a mult/div busy counter
// and the muldiv_busy port.
module hazard_tag_pipe
  import hazard_tag_pipe_pkg::*;
#(
  parameter logic [4:0] RA_REG   = 5'd31,
  parameter int         BUSY_MUL = 5,
  parameter int         BUSY_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        stall,
  input  logic        flush_e,
  output logic [1:0]  res_e,
  output logic [1:0]  res_m,
  output logic [1:0]  res_w,
  output logic [4:0]  A3_e,
  output logic [4:0]  A3_m,
  output logic [4:0]  A3_w,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m
`ifdef MULDIV_BUSY_EN
  ,
  output logic        muldiv_busy
`endif
);

  tag_t       tag_dec;
  tag_t       tag_e_q, tag_e_d, tag_m_q, tag_w_q;
  logic [4:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d, rt_m_q;
  logic       bubble;

  hazard_tag_decode #(.RA_REG(RA_REG)) u_decode (
    .instr_i (instr_d),
    .tag_o   (tag_dec)
  );

  // stall and flush_e collapse into one bubble request.
  assign bubble = stall | flush_e;

  // E-stage next state: decoded D tag, or an empty tag on a bubble.
  always_comb begin
    tag_e_d = tag_dec;
    rs_e_d  = instr_d[25:21];
    rt_e_d  = instr_d[20:16];
    if (bubble) begin
      tag_e_d = '{res: RES_NW, a3: 5'd0};
      rs_e_d  = 5'd0;
      rt_e_d  = 5'd0;
    end
  end

  // Tag pipeline registers; M and W always advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_e_q <= '{res: RES_NW, a3: 5'd0};
      tag_m_q <= '{res: RES_NW, a3: 5'd0};
      tag_w_q <= '{res: RES_NW, a3: 5'd0};
      rs_e_q  <= 5'd0;
      rt_e_q  <= 5'd0;
      rt_m_q  <= 5'd0;
    end else begin
      tag_e_q <= tag_e_d;
      rs_e_q  <= rs_e_d;
      rt_e_q  <= rt_e_d;
      tag_m_q <= tag_e_q;
      rt_m_q  <= rt_e_q;
      tag_w_q <= tag_m_q;
    end
  end

  assign res_e = tag_e_q.res;
  assign res_m = tag_m_q.res;
  assign res_w = tag_w_q.res;
  assign A3_e  = tag_e_q.a3;
  assign A3_m  = tag_m_q.a3;
  assign A3_w  = tag_w_q.a3;

  // Forwarding selects from the registered tags.
  always_comb begin
    fwd_rs_d = fwd_d_sel(instr_d[25:21], tag_e_q, tag_m_q, tag_w_q);
    fwd_rt_d = fwd_d_sel(instr_d[20:16], tag_e_q, tag_m_q, tag_w_q);
    fwd_rs_e = fwd_e_sel(rs_e_q, tag_m_q, tag_w_q);
    fwd_rt_e = fwd_e_sel(rt_e_q, tag_m_q, tag_w_q);
    fwd_rt_m = (tag_w_q.res != RES_NW) && (rt_m_q != 5'd0) && (tag_w_q.a3 == rt_m_q);
  end

`ifdef MULDIV_BUSY_EN
  logic [3:0] busy_cnt_q, busy_cnt_d;

  // Reload on an un-bubbled mult/div entering E (div has funct bit 1 set),
  // otherwise count down to zero.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (!bubble && is_muldiv(instr_d))
      busy_cnt_d = instr_d[1] ? 4'(BUSY_DIV) : 4'(BUSY_MUL);
    else if (busy_cnt_q != 4'd0)
      busy_cnt_d = busy_cnt_q - 4'd1;
  end

  // Busy counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_cnt_q <= 4'd0;
    else       busy_cnt_q <= busy_cnt_d;
  end

  assign muldiv_busy = (busy_cnt_q != 4'd0);
`else
  localparam int unused_busy_cycles = BUSY_MUL + BUSY_DIV;
`endif

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Self-checking bench for hazard_tag_pipe: a decode/bubble vector table
// followed by hand-written multi-cycle forwarding and reset sequences.
// Define MULDIV_BUSY_EN to also exercise the busy counter.
module tb_hazard_tag_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = 32'd0;
  logic        stall = 1'b0;
  logic        flush_e = 1'b0;
  logic [1:0]  res_e, res_m, res_w;
  logic [4:0]  A3_e, A3_m, A3_w;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic        fwd_rt_m;
`ifdef MULDIV_BUSY_EN
  logic        muldiv_busy;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_tag_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .instr_d  (instr_d),
    .stall    (stall),
    .flush_e  (flush_e),
    .res_e    (res_e),
    .res_m    (res_m),
    .res_w    (res_w),
    .A3_e     (A3_e),
    .A3_m     (A3_m),
    .A3_w     (A3_w),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .fwd_rt_m (fwd_rt_m)
`ifdef MULDIV_BUSY_EN
    ,
    .muldiv_busy (muldiv_busy)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic [1:0]  res;
    logic [4:0]  a3;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    instr_d = 32'd0;
    stall   = 1'b0;
    flush_e = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    vecs[0]  = '{"addu_r3",      enc_r(5'd1, 5'd2, 5'd3, 6'h21),      1'b0, 1'b0, 2'b01, 5'd3};
    vecs[1]  = '{"jr",           enc_r(5'd31, 5'd0, 5'd0, 6'h08),     1'b0, 1'b0, 2'b00, 5'd0};
    vecs[2]  = '{"jalr_r5",      enc_r(5'd4, 5'd0, 5'd5, 6'h09),      1'b0, 1'b0, 2'b11, 5'd5};
    vecs[3]  = '{"ori_r6",       enc_i(6'h0D, 5'd1, 5'd6, 16'h12),    1'b0, 1'b0, 2'b01, 5'd6};
    vecs[4]  = '{"lui_r7",       enc_i(6'h0F, 5'd0, 5'd7, 16'h1),     1'b0, 1'b0, 2'b01, 5'd7};
    vecs[5]  = '{"slti_r8",      enc_i(6'h0A, 5'd1, 5'd8, 16'h5),     1'b0, 1'b0, 2'b01, 5'd8};
    vecs[6]  = '{"lw_r9",        enc_i(6'h23, 5'd1, 5'd9, 16'h4),     1'b0, 1'b0, 2'b10, 5'd9};
    vecs[7]  = '{"lbu_r10",      enc_i(6'h24, 5'd1, 5'd10, 16'h0),    1'b0, 1'b0, 2'b10, 5'd10};
    vecs[8]  = '{"jal",          {6'h03, 26'h10},                     1'b0, 1'b0, 2'b11, 5'd31};
    vecs[9]  = '{"sw",           enc_i(6'h2B, 5'd1, 5'd9, 16'h4),     1'b0, 1'b0, 2'b00, 5'd0};
    vecs[10] = '{"beq",          enc_i(6'h04, 5'd1, 5'd2, 16'h3),     1'b0, 1'b0, 2'b00, 5'd0};
    vecs[11] = '{"unknown_op",   enc_i(6'h3F, 5'd1, 5'd12, 16'h0),    1'b0, 1'b0, 2'b00, 5'd0};
    vecs[12] = '{"addu_r0",      enc_r(5'd1, 5'd2, 5'd0, 6'h21),      1'b0, 1'b0, 2'b00, 5'd0};
    vecs[13] = '{"mult_rd13",    enc_r(5'd1, 5'd2, 5'd13, 6'h18),     1'b0, 1'b0, 2'b00, 5'd0};
    vecs[14] = '{"addu_stall",   enc_r(5'd1, 5'd2, 5'd3, 6'h21),      1'b1, 1'b0, 2'b00, 5'd0};
    vecs[15] = '{"addu_flush",   enc_r(5'd1, 5'd2, 5'd3, 6'h21),      1'b0, 1'b1, 2'b00, 5'd0};
    vecs[16] = '{"addu_both",    enc_r(5'd1, 5'd2, 5'd3, 6'h21),      1'b1, 1'b1, 2'b00, 5'd0};
    vecs[17] = '{"addiu_rt0",    enc_i(6'h09, 5'd1, 5'd0, 16'h7),     1'b0, 1'b0, 2'b00, 5'd0};
    vecs[18] = '{"lh_r11",       enc_i(6'h21, 5'd2, 5'd11, 16'h2),    1'b0, 1'b0, 2'b10, 5'd11};
    vecs[19] = '{"andi_r12",     enc_i(6'h0C, 5'd2, 5'd12, 16'hF),    1'b0, 1'b0, 2'b01, 5'd12};
    vecs[20] = '{"j",            {6'h02, 26'h20},                     1'b0, 1'b0, 2'b00, 5'd0};
    vecs[21] = '{"divu",         enc_r(5'd1, 5'd2, 5'd0, 6'h1B),      1'b0, 1'b0, 2'b00, 5'd0};

    // Reset state.
    #12;
    chk("rst_res_e", 32'(res_e), 32'd0);
    chk("rst_res_w", 32'(res_w), 32'd0);
    chk("rst_A3_m", 32'(A3_m), 32'd0);
    chk("rst_fwd_rt_m", 32'(fwd_rt_m), 32'd0);
    reset = 1'b0;
    step();

    // Decode and bubble table: one edge per vector, E tag compared.
    for (int i = 0; i < NV; i++) begin
      instr_d = vecs[i].instr;
      stall   = vecs[i].stall;
      flush_e = vecs[i].flush;
      step();
      $display("vec %0d %s: res_e=%0d A3_e=%0d", i, vecs[i].name, res_e, A3_e);
      chk({vecs[i].name, "_res_e"}, 32'(res_e), 32'(vecs[i].res));
      chk({vecs[i].name, "_A3_e"}, 32'(A3_e), 32'(vecs[i].a3));
    end

    // addu $3 then subu $5,$3,$3: E forwarding from M, W latency.
    drain();
    instr_d = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
    step();
    chk("seq_addu_res_e", 32'(res_e), 32'd1);
    chk("seq_addu_A3_e", 32'(A3_e), 32'd3);
    instr_d = enc_r(5'd3, 5'd3, 5'd5, 6'h23);
    #1;
    chk("seq_subu_fwd_rs_d_alu_in_e", 32'(fwd_rs_d), 32'd0);
    step();
    $display("seq subu in E: fwd_rs_e=%0d fwd_rt_e=%0d", fwd_rs_e, fwd_rt_e);
    chk("seq_subu_fwd_rs_e", 32'(fwd_rs_e), 32'd2);
    chk("seq_subu_fwd_rt_e", 32'(fwd_rt_e), 32'd2);
    instr_d = 32'd0;
    step();
    chk("seq_addu_res_w", 32'(res_w), 32'd1);
    chk("seq_addu_A3_w", 32'(A3_w), 32'd3);

    // E operand forwarded from W.
    drain();
    instr_d = enc_r(5'd1, 5'd2, 5'd8, 6'h21);
    step();
    instr_d = 32'd0;
    step();
    instr_d = enc_r(5'd8, 5'd8, 5'd9, 6'h21);
    step();
    chk("seq_w_fwd_rs_e", 32'(fwd_rs_e), 32'd3);
    chk("seq_w_fwd_rt_e", 32'(fwd_rt_e), 32'd3);

    // lw $4 stalled one cycle: tag reaches M one cycle late.
    drain();
    instr_d = enc_i(6'h23, 5'd1, 5'd4, 16'h0);
    stall = 1'b1;
    step();
    chk("stall_res_e", 32'(res_e), 32'd0);
    chk("stall_A3_e", 32'(A3_e), 32'd0);
    stall = 1'b0;
    step();
    chk("stall_lw_res_e", 32'(res_e), 32'd2);
    chk("stall_lw_res_m_empty", 32'(res_m), 32'd0);
    instr_d = 32'd0;
    step();
    chk("stall_lw_res_m", 32'(res_m), 32'd2);
    chk("stall_lw_A3_m", 32'(A3_m), 32'd4);

    // jal in E, beq $31 in D: forward from E, then M, then W.
    drain();
    instr_d = {6'h03, 26'h40};
    step();
    chk("jal_res_e", 32'(res_e), 32'd3);
    chk("jal_A3_e", 32'(A3_e), 32'd31);
    instr_d = enc_i(6'h04, 5'd31, 5'd0, 16'h2);
    #1;
    chk("jal_fwd_rs_d_e", 32'(fwd_rs_d), 32'd1);
    chk("jal_fwd_rt_d_r0", 32'(fwd_rt_d), 32'd0);
    step();
    chk("jal_fwd_rs_d_m", 32'(fwd_rs_d), 32'd2);
    step();
    chk("jal_fwd_rs_d_w", 32'(fwd_rs_d), 32'd3);

    // addu $0 is NW; rs=0 consumer never forwards.
    drain();
    instr_d = enc_r(5'd1, 5'd2, 5'd0, 6'h21);
    step();
    instr_d = enc_r(5'd0, 5'd0, 5'd6, 6'h21);
    #1;
    chk("r0_res_e", 32'(res_e), 32'd0);
    chk("r0_fwd_rs_d", 32'(fwd_rs_d), 32'd0);

    // lw $7 then sw $7: no E select for DM in M, store data from W.
    drain();
    instr_d = enc_i(6'h23, 5'd1, 5'd7, 16'h0);
    step();
    instr_d = enc_i(6'h2B, 5'd1, 5'd7, 16'h4);
    step();
    chk("lwsw_fwd_rt_e_dm", 32'(fwd_rt_e), 32'd0);
    instr_d = 32'd0;
    step();
    $display("seq sw in M: fwd_rt_m=%0d", fwd_rt_m);
    chk("lwsw_fwd_rt_m", 32'(fwd_rt_m), 32'd1);

    // Reset mid-stream, between edges.
    drain();
    instr_d = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
    step();
    instr_d = enc_i(6'h23, 5'd1, 5'd4, 16'h0);
    step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_res_e", 32'(res_e), 32'd0);
    chk("mid_rst_A3_e", 32'(A3_e), 32'd0);
    chk("mid_rst_res_m", 32'(res_m), 32'd0);
    chk("mid_rst_A3_m", 32'(A3_m), 32'd0);
    #2 reset = 1'b0;

`ifdef MULDIV_BUSY_EN
    drain();
    chk("busy_idle", 32'(muldiv_busy), 32'd0);
    instr_d = enc_r(5'd1, 5'd2, 5'd0, 6'h18);
    stall = 1'b1;
    step();
    chk("busy_stalled_mult", 32'(muldiv_busy), 32'd0);
    stall = 1'b0;
    step();
    instr_d = 32'd0;
    chk("busy_mult_0", 32'(muldiv_busy), 32'd1);
    for (int k = 1; k < 5; k++) begin
      step();
      chk("busy_mult_hold", 32'(muldiv_busy), 32'd1);
    end
    step();
    chk("busy_mult_done", 32'(muldiv_busy), 32'd0);
    instr_d = enc_r(5'd1, 5'd2, 5'd0, 6'h18);
    step();
    instr_d = 32'd0;
    step();
    instr_d = enc_r(5'd1, 5'd2, 5'd0, 6'h1A);
    step();
    instr_d = 32'd0;
    chk("busy_div_0", 32'(muldiv_busy), 32'd1);
    for (int k = 1; k < 10; k++) begin
      step();
      chk("busy_div_hold", 32'(muldiv_busy), 32'd1);
    end
    step();
    chk("busy_div_done", 32'(muldiv_busy), 32'd0);
    instr_d = enc_r(5'd1, 5'd2, 5'd0, 6'h19);
    step();
    instr_d = 32'd0;
    chk("busy_multu", 32'(muldiv_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("busy_reset", 32'(muldiv_busy), 32'd0);
    #2 reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_tag_pipe.md
Name: hazard_tag_pipe

Overview:
- Producer side of the stall-detection interface: decodes the D-stage instruction into a result class and destination register.
- Carries that (class, A3) tag through E, M and W pipeline registers, driving res_e/m/w and A3_e/m/w to the stall detector.
- Consumes the detector's stall_data to insert E-stage bubbles.
- From the same tags, generates forwarding-mux selects for D, E and M operands.

Parameters:
- RA_REG, 5'd31: destination register written by jal.
- BUSY_MUL, 5: busy cycles for mult/multu (MULDIV_BUSY_EN only).
- BUSY_DIV, 10: busy cycles for div/divu (MULDIV_BUSY_EN only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr_d  in  32  instruction currently in D.
- stall  in  1  stall_data from stall detector; bubble E this cycle.
- flush_e  in  1  force E bubble (branch/exception squash).
- res_e, res_m, res_w  out  2  result class per stage: 01 ALU, 10 DM, 11 PC, 00 NW.
- A3_e, A3_m, A3_w  out  5  destination register per stage.
- fwd_rs_d, fwd_rt_d  out  2  D operand select: 00 regfile, 01 E, 10 M, 11 W.
- fwd_rs_e, fwd_rt_e  out  2  E operand select: 00 pipe value, 10 M, 11 W.
- fwd_rt_m  out  1  M store-data select: 1 = from W.
- muldiv_busy  out  1  present only with MULDIV_BUSY_EN.

Behaviour:
- Reset (async, immediate): all res_* = 00, all A3_* = 0, internal rs_e/rt_e/rt_m = 0, all fwd_* = 0, busy counter = 0.
- Decode of instr_d is combinational:
  - R-type (op 0) with funct jr (001000): NW.
  - jalr (001001): PC, A3 = rd.
  - Other R-type: ALU, A3 = rd.
  - ori, andi, addiu, addi, lui, slti: ALU, A3 = rt.
  - lw, lh, lb, lbu, lhu: DM, A3 = rt.
  - jal: PC, A3 = RA_REG.
  - sw, beq, bne, j and any unknown opcode: NW, A3 = 0.
  - Any decoded A3 = 0 forces class NW.
- Clock edge, E stage:
  - If stall or flush_e: E tag <= {NW, 0}, rs_e/rt_e <= 0.
  - Otherwise: E <= decoded D tag plus rs/rt fields of instr_d.
- Clock edge, M and W: M <= E and W <= M unconditionally; these stages never stall.
- Tag latency: D to res_e is 1 cycle, to res_m 2 cycles, to res_w 3 cycles.
- Forwarding selects are combinational from registered tags.
  - D: nearest match wins. Priority E (res_e == PC only), then M (res_m ∈ {ALU, PC}), then W (res_w != NW).
  - E: M (res_m ∈ {ALU, PC}), then W.
  - M: fwd_rt_m = res_w != NW && A3_w == rt_m.
  - Register 0 never forwards.
  - A DM-class match in E, or in M for D, yields no select; the stall detector owns that case.
- stall and flush_e in the same cycle: single bubble, identical to either alone.

Optional Feature:
- Macro MULDIV_BUSY_EN.
- When defined:
  - The muldiv_busy port exists.
  - A 4-bit down-counter loads BUSY_MUL or BUSY_DIV when an un-bubbled mult/multu/div/divu enters E.
  - The counter decrements each cycle to 0; muldiv_busy = counter != 0.
  - A new mult/div entering while busy reloads the counter.
  - Reset clears the counter.
- When undefined: no port, no counter; the decode still classifies mult/div as NW.

Decomposition:
- Shared package/header: result-class codes (ALU/DM/PC/NW), opcode and funct constants, fwd select encodings. The stall detector uses the same package.
- One natural sub-module, hazard_tag_decode: purely combinational instr → {class, A3}.

Test Plan:
- Reset mid-stream: stream addu $3 and lw $4, then assert reset between edges → all res_*/A3_* read 0 immediately, before the next edge.
- addu $3,$1,$2 then subu $5,$3,$3: cycle 1 res_e=01, A3_e=3; cycle 2 fwd_rs_e=fwd_rt_e=10; cycle 3 res_w=01, A3_w=3.
- lw $4 with stall=1 for 1 cycle: E holds {00,0} that cycle, lw tag appears in M one cycle later than unstalled; M/W continue advancing.
- jal in E, beq $31 in D: res_e=11, A3_e=31, fwd_rs_d=01.
- addu $0,$1,$2 → res_e=00, no forwarding to rs=0 consumers; sw after lw same rt: fwd_rt_m=1.
- MULDIV_BUSY_EN: mult enters E → muldiv_busy high 5 cycles; div issued 2 cycles later → busy extends 10 more cycles; reset clears immediately.
